// File: rtl/xor_tn_pipe.sv
// xor_tn_pipe: two-stage ready/valid pipeline of per-trit balanced-ternary XOR/XNOR/MIN/MAX
module xor_tn_pipe #(
    parameter int TRITS = 9,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [2*TRITS-1:0]   a,
    input  logic [2*TRITS-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*TRITS-1:0]   c,
    output logic [TRITS-1:0]     err_mask,
    output logic                 err,
    output logic [CNT_W-1:0]     err_cnt,
    input  logic                 err_clr
);
    logic                 s1_valid;
    logic                 s2_valid;
    logic [2*TRITS-1:0]   s1_a;
    logic [2*TRITS-1:0]   s1_b;
    logic [1:0]           s1_op;
    logic [TRITS-1:0]     s1_bad;
    logic [TRITS-1:0]     bad_in;
    logic [2*TRITS-1:0]   c_next;
    logic                 s2_free;
    logic                 accept;
    logic                 s2_take;
    logic                 xfer;

    // Trit codes: 10 = +1, 00 = 0, 01 = -1; operands are assumed legal here.
    function automatic logic [1:0] trit_op(input logic [1:0] f, input logic [1:0] x, input logic [1:0] y);
        logic zero, same, neg, pos;
        zero = (x == 2'b00) || (y == 2'b00);
        same = x == y;
        neg  = (x == 2'b01) || (y == 2'b01);
        pos  = (x == 2'b10) || (y == 2'b10);
        return (f == 2'b00) ? (zero ? 2'b00 : same ? 2'b01 : 2'b10) :
               (f == 2'b01) ? (zero ? 2'b00 : same ? 2'b10 : 2'b01) :
               (f == 2'b10) ? (neg ? 2'b01 : zero ? 2'b00 : 2'b10) :
                              (pos ? 2'b10 : zero ? 2'b00 : 2'b01);
    endfunction

    assign s2_free   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_free;
    assign accept    = in_valid && in_ready;
    assign s2_take   = s1_valid && s2_free;
    assign xfer      = s2_valid && out_ready;
    assign out_valid = s2_valid;
    assign err       = s2_valid && (|err_mask);

    // Flag incoming trits carrying the illegal code 11 in either operand.
    always_comb begin
        bad_in = '0;
        for (int t = 0; t < TRITS; t++)
            bad_in[t] = (&a[2*t +: 2]) || (&b[2*t +: 2]);
    end

    // Per-trit result from stage 1; illegal trits are forced to zero.
    always_comb begin
        c_next = '0;
        for (int t = 0; t < TRITS; t++)
            c_next[2*t +: 2] = s1_bad[t] ? 2'b00 : trit_op(s1_op, s1_a[2*t +: 2], s1_b[2*t +: 2]);
    end

    // Stage 1: capture operands, op and illegal flags on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s1_bad   <= '0;
        end else begin
            s1_valid <= accept || (s1_valid && !s2_take);
            if (accept) begin
                s1_a   <= a;
                s1_b   <= b;
                s1_op  <= op;
                s1_bad <= bad_in;
            end
        end
    end

    // Stage 2: register the result; it holds while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            c        <= '0;
            err_mask <= '0;
        end else begin
            s2_valid <= s2_take || (s2_valid && !out_ready);
            if (s2_take) begin
                c        <= c_next;
                err_mask <= s1_bad;
            end
        end
    end

    // Saturating count of delivered erroneous words; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (err_clr)
            err_cnt <= '0;
        else if (xfer && err && err_cnt != {CNT_W{1'b1}})
            err_cnt <= err_cnt + 1'b1;
    end
endmodule

// File: tb/tb_xor_tn_pipe.sv
// tb_xor_tn_pipe: randomized scoreboard bench for xor_tn_pipe against an arithmetic ternary model
module tb_xor_tn_pipe;
    localparam int TRITS = 9;
    localparam int CNT_W = 2;
    localparam int W = 2 * TRITS;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     c;
    logic [TRITS-1:0] err_mask;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic             err_clr;

    logic [W-1:0]     exp_c[$];
    logic [TRITS-1:0] exp_m[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               n_acc = 0;
    int               model_cnt = 0;

    xor_tn_pipe #(.TRITS(TRITS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c),
        .err_mask(err_mask), .err(err), .err_cnt(err_cnt), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int dec(input logic [1:0] v);
        return (v == 2'b10) ? 1 : (v == 2'b01) ? -1 : 0;
    endfunction

    function automatic logic [1:0] enc(input int v);
        return (v > 0) ? 2'b10 : (v < 0) ? 2'b01 : 2'b00;
    endfunction

    // Reference: decode each trit to an integer, apply the arithmetic rule, re-encode.
    task automatic model(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] rc, output logic [TRITS-1:0] rm);
        rc = '0;
        rm = '0;
        for (int i = 0; i < TRITS; i++) begin
            logic [1:0] tx, ty;
            int xi, yi, r;
            tx = x[2*i +: 2];
            ty = y[2*i +: 2];
            if (tx == 2'b11 || ty == 2'b11) begin
                rm[i] = 1'b1;
            end else begin
                xi = dec(tx);
                yi = dec(ty);
                case (f)
                    2'd0: r = -(xi * yi);
                    2'd1: r = xi * yi;
                    2'd2: r = (xi < yi) ? xi : yi;
                    default: r = (xi > yi) ? xi : yi;
                endcase
                rc[2*i +: 2] = enc(r);
            end
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        int r;
        for (int i = 0; i < TRITS; i++) begin
            r = $urandom % 20;
            w[2*i +: 2] = (r == 0) ? 2'b11 : (r < 7) ? 2'b10 : (r < 13) ? 2'b01 : 2'b00;
        end
        return w;
    endfunction

    // Monitor: record accepted words into the scoreboard and check delivered ones.
    always @(negedge clk) begin
        if (!rst) begin
            logic [W-1:0]     ec;
            logic [TRITS-1:0] em;
            logic             xerr;
            xerr = 1'b0;
            if (in_valid && in_ready) begin
                model(op, a, b, ec, em);
                exp_c.push_back(ec);
                exp_m.push_back(em);
                n_acc++;
            end
            if (!out_valid)
                chk("err_idle", {63'd0, err}, 64'd0);
            if (out_valid && out_ready) begin
                if (exp_c.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got c=%0h, expected no word", c);
                end else begin
                    ec = exp_c.pop_front();
                    em = exp_m.pop_front();
                    xerr = |em;
                    chk("c", {46'd0, c}, {46'd0, ec});
                    chk("err_mask", {55'd0, err_mask}, {55'd0, em});
                    chk("err", {63'd0, err}, {63'd0, xerr});
                end
            end
            chk("err_cnt", {62'd0, err_cnt}, 64'(model_cnt));
            if (err_clr)
                model_cnt = 0;
            else if (xerr && model_cnt < (1 << CNT_W) - 1)
                model_cnt++;
        end
    end

    task automatic send(input logic [1:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        op = f;
        a = x;
        b = y;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        err_clr = 1'b0;
        for (int k = 0; k < 20 && (exp_c.size() != 0 || out_valid); k++)
            @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_c.size()), 64'd0);
    endtask

    initial begin
        int n0;
        logic [W-1:0] w37;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        err_clr = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        #3;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_c", {46'd0, c}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_err_cnt", {62'd0, err_cnt}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed words: XOR truth pairs, MIN with an illegal trit, XNOR and MAX.
        out_ready = 1'b1;
        send(2'b00, 18'b10, 18'b10);
        send(2'b00, 18'b10, 18'b01);
        send(2'b00, 18'b00, 18'b01);
        send(2'b00, 18'b01, 18'b01);
        w37 = {9{2'b10}};
        w37[7:6] = 2'b11;
        send(2'b10, w37, {9{2'b01}});
        send(2'b01, {9{2'b10}}, {9{2'b01}});
        send(2'b11, {9{2'b10}}, {9{2'b01}});
        drain();

        // Random traffic with random back-pressure and occasional counter clears.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            err_clr = ($urandom % 16) == 0;
            op = 2'($urandom);
            a = rand_word();
            b = rand_word();
        end
        drain();

        // Stall: only two words fit while downstream is blocked.
        n0 = n_acc;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            op = 2'($urandom);
            a = rand_word();
            b = rand_word();
        end
        @(negedge clk);
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_accepted", 64'(n_acc - n0), 64'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && (n_acc - n0) < 4; k++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
            op = 2'($urandom);
            a = rand_word();
            b = rand_word();
        end
        in_valid = 1'b0;
        chk("stall_total", 64'(n_acc - n0), 64'd4);
        drain();

        // Reset mid-stall with two erroneous words in flight.
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = 2'b00;
        a = {9{2'b11}};
        b = {9{2'b10}};
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_err_cnt", {62'd0, err_cnt}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        exp_c.delete();
        exp_m.delete();
        model_cnt = 0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = 2'b11;
        a = rand_word();
        b = rand_word();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_cycle2", {63'd0, out_valid}, 64'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
